// File: rtl/clint_tmr.sv
// Minimal CLINT for the cirno9 core: free-running 64-bit mtime, mtimecmp and msip
// behind a single-outstanding request/response port; drives the core's tmr_ip/sft_ip.
module clint_tmr #(
    parameter int unsigned PRESCALE = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_vld,
    output logic        req_rdy,
    input  logic        req_wen,
    input  logic [15:0] req_addr,
    input  logic [31:0] req_wdat,
    output logic        rsp_vld,
    input  logic        rsp_rdy,
    output logic [31:0] rsp_rdat,
    output logic        rsp_err,
    output logic        tmr_ip,
    output logic        sft_ip
);

    typedef enum logic [2:0] {
        SEL_NONE,
        SEL_MSIP,
        SEL_CMP_LO,
        SEL_CMP_HI,
        SEL_TIME_LO,
        SEL_TIME_HI
    } reg_sel_e;

    localparam logic [15:0] PRESC_LAST = 16'(PRESCALE - 1);

    logic [15:0] presc_q, presc_d;
    logic [63:0] mtime_q, mtime_d;
    logic [63:0] mtimecmp_q, mtimecmp_d;
    logic        msip_q, msip_d;
    logic        tmr_ip_q, tmr_ip_d;
    logic        rsp_vld_q, rsp_vld_d;
    logic        rsp_err_q, rsp_err_d;
    logic [31:0] rsp_rdat_q, rsp_rdat_d;

    logic        accept;
    logic        wr_acc;
    logic        tick;
    reg_sel_e    sel;
    logic [31:0] rd_data;
    logic        unused_addr_lsb;

    // Word-aligned register map: the two byte-offset bits carry no meaning.
    assign unused_addr_lsb = ^req_addr[1:0];

    assign req_rdy = !rsp_vld_q || rsp_rdy;
    assign accept  = req_vld && req_rdy;
    assign wr_acc  = accept && req_wen;
    assign tick    = (presc_q == PRESC_LAST);

    always_comb begin
        sel = SEL_NONE;
        case (req_addr[15:2])
            14'h0000: sel = SEL_MSIP;
            14'h1000: sel = SEL_CMP_LO;
            14'h1001: sel = SEL_CMP_HI;
            14'h2FFE: sel = SEL_TIME_LO;
            14'h2FFF: sel = SEL_TIME_HI;
            default:  sel = SEL_NONE;
        endcase
    end

    always_comb begin
        rd_data = '0;
        case (sel)
            SEL_MSIP:    rd_data = {31'd0, msip_q};
            SEL_CMP_LO:  rd_data = mtimecmp_q[31:0];
            SEL_CMP_HI:  rd_data = mtimecmp_q[63:32];
            SEL_TIME_LO: rd_data = mtime_q[31:0];
            SEL_TIME_HI: rd_data = mtime_q[63:32];
            default:     rd_data = '0;
        endcase
    end

    // A software write to mtime wins over the tick and restarts the prescale period.
    always_comb begin
        presc_d = tick ? '0 : presc_q + 16'd1;
        mtime_d = tick ? mtime_q + 64'd1 : mtime_q;
        if (wr_acc && sel == SEL_TIME_LO) begin
            mtime_d = {mtime_q[63:32], req_wdat};
            presc_d = '0;
        end else if (wr_acc && sel == SEL_TIME_HI) begin
            mtime_d = {req_wdat, mtime_q[31:0]};
            presc_d = '0;
        end
    end

    always_comb begin
        mtimecmp_d = mtimecmp_q;
        msip_d     = msip_q;
        if (wr_acc) begin
            case (sel)
                SEL_MSIP:   msip_d = req_wdat[0];
                SEL_CMP_LO: mtimecmp_d = {mtimecmp_q[63:32], req_wdat};
                SEL_CMP_HI: mtimecmp_d = {req_wdat, mtimecmp_q[31:0]};
                default:    ;
            endcase
        end
    end

    assign tmr_ip_d = (mtime_q >= mtimecmp_q);

    always_comb begin
        rsp_vld_d  = rsp_vld_q;
        rsp_err_d  = rsp_err_q;
        rsp_rdat_d = rsp_rdat_q;
        if (accept) begin
            rsp_vld_d  = 1'b1;
            rsp_err_d  = (sel == SEL_NONE);
            rsp_rdat_d = req_wen ? '0 : rd_data;
        end else if (rsp_rdy) begin
            rsp_vld_d  = 1'b0;
            rsp_err_d  = 1'b0;
            rsp_rdat_d = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            presc_q    <= '0;
            mtime_q    <= '0;
            mtimecmp_q <= '1;
            msip_q     <= 1'b0;
            tmr_ip_q   <= 1'b0;
            rsp_vld_q  <= 1'b0;
            rsp_err_q  <= 1'b0;
            rsp_rdat_q <= '0;
        end else begin
            presc_q    <= presc_d;
            mtime_q    <= mtime_d;
            mtimecmp_q <= mtimecmp_d;
            msip_q     <= msip_d;
            tmr_ip_q   <= tmr_ip_d;
            rsp_vld_q  <= rsp_vld_d;
            rsp_err_q  <= rsp_err_d;
            rsp_rdat_q <= rsp_rdat_d;
        end
    end

    assign rsp_vld  = rsp_vld_q;
    assign rsp_err  = rsp_err_q;
    assign rsp_rdat = rsp_rdat_q;
    assign tmr_ip   = tmr_ip_q;
    assign sft_ip   = msip_q;

endmodule

// File: tb/tb_clint_tmr.sv
// Bench for clint_tmr: three instances (PRESCALE 65535, 4, 1) share one request stream
// and are checked against a closed-form timer model.
module tb_clint_tmr;
    localparam int NI = 3;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic        req_vld, req_wen, rsp_rdy;
    logic [15:0] req_addr;
    logic [31:0] req_wdat;
    logic        req_rdy  [NI];
    logic        rsp_vld  [NI];
    logic        rsp_err  [NI];
    logic [31:0] rsp_rdat [NI];
    logic        tmr_ip   [NI];
    logic        sft_ip   [NI];

    clint_tmr #(.PRESCALE(65535)) u_dut_slow (
        .clk(clk), .rst(rst), .req_vld(req_vld), .req_rdy(req_rdy[0]), .req_wen(req_wen),
        .req_addr(req_addr), .req_wdat(req_wdat), .rsp_vld(rsp_vld[0]), .rsp_rdy(rsp_rdy),
        .rsp_rdat(rsp_rdat[0]), .rsp_err(rsp_err[0]), .tmr_ip(tmr_ip[0]), .sft_ip(sft_ip[0]));
    clint_tmr #(.PRESCALE(4)) u_dut_p4 (
        .clk(clk), .rst(rst), .req_vld(req_vld), .req_rdy(req_rdy[1]), .req_wen(req_wen),
        .req_addr(req_addr), .req_wdat(req_wdat), .rsp_vld(rsp_vld[1]), .rsp_rdy(rsp_rdy),
        .rsp_rdat(rsp_rdat[1]), .rsp_err(rsp_err[1]), .tmr_ip(tmr_ip[1]), .sft_ip(sft_ip[1]));
    clint_tmr #(.PRESCALE(1)) u_dut_p1 (
        .clk(clk), .rst(rst), .req_vld(req_vld), .req_rdy(req_rdy[2]), .req_wen(req_wen),
        .req_addr(req_addr), .req_wdat(req_wdat), .rsp_vld(rsp_vld[2]), .rsp_rdy(rsp_rdy),
        .rsp_rdat(rsp_rdat[2]), .rsp_err(rsp_err[2]), .tmr_ip(tmr_ip[2]), .sft_ip(sft_ip[2]));

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int errors = 0;
    int checks = 0;

    // Model: after edge e, mtime = base + floor((e - e0) / PRESCALE); one level of history
    // is kept so values just before the latest write are still available.
    int          ps [NI] = '{65535, 4, 1};
    logic [63:0] t_base [NI];
    logic [63:0] t_pbase [NI];
    int          t_e0 [NI];
    int          t_pe0 [NI];
    logic [63:0] c_cur, c_old;
    int          c_edge;
    logic        m_msip;

    int          obs_ea;
    logic [31:0] obs_rdat [NI];
    logic        obs_err [NI];
    logic        obs_vld [NI];
    logic        obs_sft [NI];

    function automatic logic [63:0] mt(int i, int e);
        if (e >= t_e0[i]) return t_base[i] + 64'((e - t_e0[i]) / ps[i]);
        return t_pbase[i] + 64'((e - t_pe0[i]) / ps[i]);
    endfunction

    function automatic logic [63:0] cmp_at(int e);
        return (e >= c_edge) ? c_cur : c_old;
    endfunction

    function automatic logic tmr_exp(int i, int e);
        return mt(i, e - 1) >= cmp_at(e - 1);
    endfunction

    function automatic logic mapped(logic [15:0] a);
        return a[15:2] == 14'h0000 || a[15:2] == 14'h1000 || a[15:2] == 14'h1001 ||
               a[15:2] == 14'h2FFE || a[15:2] == 14'h2FFF;
    endfunction

    function automatic logic [31:0] exp_rdat(int i, logic wen, logic [15:0] a, int ea);
        logic [63:0] t, c;
        t = mt(i, ea - 1);
        c = cmp_at(ea - 1);
        if (wen) return 32'd0;
        case (a[15:2])
            14'h0000: return {31'd0, m_msip};
            14'h1000: return c[31:0];
            14'h1001: return c[63:32];
            14'h2FFE: return t[31:0];
            14'h2FFF: return t[63:32];
            default:  return 32'd0;
        endcase
    endfunction

    function automatic void model_reset(int er);
        for (int i = 0; i < NI; i++) begin
            t_base[i] = '0; t_pbase[i] = '0; t_e0[i] = er; t_pe0[i] = er;
        end
        c_cur = '1; c_old = '1; c_edge = er; m_msip = 1'b0;
    endfunction

    function automatic void model_write(logic [15:0] a, logic [31:0] d, int ea);
        logic [63:0] v;
        case (a[15:2])
            14'h0000: m_msip = d[0];
            14'h1000: begin c_old = c_cur; c_cur[31:0] = d; c_edge = ea; end
            14'h1001: begin c_old = c_cur; c_cur[63:32] = d; c_edge = ea; end
            14'h2FFE, 14'h2FFF: begin
                for (int i = 0; i < NI; i++) begin
                    v = mt(i, ea - 1);
                    if (a[2]) v[63:32] = d; else v[31:0] = d;
                    t_pbase[i] = t_base[i]; t_pe0[i] = t_e0[i];
                    t_base[i] = v; t_e0[i] = ea;
                end
            end
            default: ;
        endcase
    endfunction

    // Drives one transaction with the response consumed promptly; records observations.
    task automatic bus(input logic wen, input logic [15:0] a, input logic [31:0] d);
        @(negedge clk);
        req_vld = 1'b1; req_wen = wen; req_addr = a; req_wdat = d; rsp_rdy = 1'b1;
        @(posedge clk); #1;
        obs_ea = cyc;
        req_vld = 1'b0;
        for (int i = 0; i < NI; i++) obs_sft[i] = sft_ip[i];
        if (wen) model_write(a, d, obs_ea);
        @(negedge clk);
        for (int i = 0; i < NI; i++) begin
            obs_vld[i] = rsp_vld[i]; obs_rdat[i] = rsp_rdat[i]; obs_err[i] = rsp_err[i];
        end
    endtask

    task automatic test_reset();
        logic [15:0] addrs [4] = '{16'hBFF8, 16'hBFFC, 16'h4000, 16'h4004};
        logic [31:0] e;
        rst = 1'b1; req_vld = 1'b0; rsp_rdy = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        model_reset(cyc);
        rst = 1'b0;
        @(negedge clk);
        for (int i = 0; i < NI; i++) begin
            checks++; if (rsp_vld[i] !== 1'b0) begin errors++; $display("FAIL reset_rsp_vld inst%0d: got %b want 0", i, rsp_vld[i]); end
            checks++; if (rsp_err[i] !== 1'b0) begin errors++; $display("FAIL reset_rsp_err inst%0d: got %b want 0", i, rsp_err[i]); end
            checks++; if (rsp_rdat[i] !== 32'd0) begin errors++; $display("FAIL reset_rsp_rdat inst%0d: got %h want 0", i, rsp_rdat[i]); end
            checks++; if (req_rdy[i] !== 1'b1) begin errors++; $display("FAIL reset_req_rdy inst%0d: got %b want 1", i, req_rdy[i]); end
            checks++; if (tmr_ip[i] !== 1'b0) begin errors++; $display("FAIL reset_tmr_ip inst%0d: got %b want 0", i, tmr_ip[i]); end
            checks++; if (sft_ip[i] !== 1'b0) begin errors++; $display("FAIL reset_sft_ip inst%0d: got %b want 0", i, sft_ip[i]); end
        end
        for (int k = 0; k < 4; k++) begin
            bus(1'b0, addrs[k], 32'd0);
            for (int i = 0; i < NI; i++) begin
                e = exp_rdat(i, 1'b0, addrs[k], obs_ea);
                checks++; if (obs_vld[i] !== 1'b1 || obs_err[i] !== 1'b0 || obs_rdat[i] !== e) begin
                    errors++; $display("FAIL reset_read %h inst%0d: got vld=%b err=%b dat=%h want 1 0 %h", addrs[k], i, obs_vld[i], obs_err[i], obs_rdat[i], e);
                end
            end
        end
        // The slowest prescaler cannot have ticked yet.
        bus(1'b0, 16'hBFF8, 32'd0);
        checks++; if (obs_rdat[0] !== 32'd0) begin errors++; $display("FAIL reset_mtime_lo_slow: got %h want 0", obs_rdat[0]); end
        bus(1'b0, 16'h4004, 32'd0);
        checks++; if (obs_rdat[0] !== 32'hFFFF_FFFF) begin errors++; $display("FAIL reset_cmp_hi: got %h want ffffffff", obs_rdat[0]); end
    endtask

    task automatic test_msip();
        bus(1'b1, 16'h0000, 32'h3);
        for (int i = 0; i < NI; i++) begin
            checks++; if (obs_sft[i] !== 1'b1) begin errors++; $display("FAIL msip_set_sft inst%0d: got %b want 1", i, obs_sft[i]); end
            checks++; if (obs_vld[i] !== 1'b1 || obs_err[i] !== 1'b0 || obs_rdat[i] !== 32'd0) begin
                errors++; $display("FAIL msip_wr_rsp inst%0d: got vld=%b err=%b dat=%h want 1 0 0", i, obs_vld[i], obs_err[i], obs_rdat[i]);
            end
        end
        bus(1'b0, 16'h0000, 32'd0);
        checks++; if (obs_rdat[1] !== 32'h1) begin errors++; $display("FAIL msip_readback: got %h want 00000001", obs_rdat[1]); end
        bus(1'b1, 16'h0000, 32'h2);
        for (int i = 0; i < NI; i++) begin
            checks++; if (obs_sft[i] !== 1'b0) begin errors++; $display("FAIL msip_clr_sft inst%0d: got %b want 0", i, obs_sft[i]); end
        end
    endtask

    task automatic test_timer_cmp();
        int rise;
        logic prev;
        logic [31:0] e;
        bus(1'b1, 16'hBFFC, 32'd0);
        bus(1'b1, 16'hBFF8, 32'd0);
        bus(1'b1, 16'h4004, 32'd0);
        bus(1'b1, 16'h4000, 32'd10);
        rise = -1;
        prev = tmr_ip[1];
        repeat (48) begin
            @(posedge clk); #1;
            for (int i = 0; i < NI; i++) begin
                checks++; if (tmr_ip[i] !== tmr_exp(i, cyc)) begin errors++; $display("FAIL timer_tmr_ip inst%0d edge %0d: got %b want %b", i, cyc, tmr_ip[i], tmr_exp(i, cyc)); end
            end
            if (rise < 0 && tmr_ip[1] && !prev) rise = cyc;
            prev = tmr_ip[1];
        end
        // mtime reaches 10 forty edges after the clearing write with PRESCALE=4.
        checks++; if (rise !== t_e0[1] + 41) begin errors++; $display("FAIL timer_rise_edge: got %0d want %0d", rise, t_e0[1] + 41); end
        bus(1'b0, 16'hBFF8, 32'd0);
        for (int i = 0; i < NI; i++) begin
            e = exp_rdat(i, 1'b0, 16'hBFF8, obs_ea);
            checks++; if (obs_rdat[i] !== e) begin errors++; $display("FAIL timer_mtime_lo inst%0d: got %h want %h", i, obs_rdat[i], e); end
        end
        bus(1'b1, 16'h4000, 32'd100);
        @(posedge clk); #1;
        checks++; if (tmr_ip[1] !== 1'b0) begin errors++; $display("FAIL timer_cmp_raise_clear: got %b want 0", tmr_ip[1]); end
        for (int i = 0; i < NI; i++) begin
            checks++; if (tmr_ip[i] !== tmr_exp(i, cyc)) begin errors++; $display("FAIL timer_after_cmp inst%0d: got %b want %b", i, tmr_ip[i], tmr_exp(i, cyc)); end
        end
    endtask

    task automatic test_carry_wrap();
        logic [15:0] rd [2] = '{16'hBFF8, 16'hBFFC};
        logic [31:0] e;
        bus(1'b1, 16'hBFF8, 32'hFFFF_FFFE);
        bus(1'b1, 16'hBFFC, 32'h0000_0005);
        for (int k = 0; k < 2; k++) begin
            bus(1'b0, rd[k], 32'd0);
            for (int i = 0; i < NI; i++) begin
                e = exp_rdat(i, 1'b0, rd[k], obs_ea);
                checks++; if (obs_rdat[i] !== e) begin errors++; $display("FAIL carry_read %h inst%0d: got %h want %h", rd[k], i, obs_rdat[i], e); end
            end
        end
        // PRESCALE=1: hi write lands on {5,ffffffff}, so the next tick carries into 6.
        checks++; if (mt(2, t_e0[2] + 1) !== {32'd6, 32'd0}) begin errors++; $display("FAIL carry_model: got %h want 0000000600000000", mt(2, t_e0[2] + 1)); end
        checks++; if (tmr_ip[2] !== 1'b1) begin errors++; $display("FAIL carry_tmr_set: got %b want 1", tmr_ip[2]); end
        bus(1'b1, 16'hBFFC, 32'hFFFF_FFFF);
        bus(1'b1, 16'hBFF8, 32'hFFFF_FFFF);
        repeat (8) begin
            @(posedge clk); #1;
            for (int i = 0; i < NI; i++) begin
                checks++; if (tmr_ip[i] !== tmr_exp(i, cyc)) begin errors++; $display("FAIL wrap_tmr_ip inst%0d edge %0d: got %b want %b", i, cyc, tmr_ip[i], tmr_exp(i, cyc)); end
            end
        end
        checks++; if (tmr_ip[2] !== 1'b0) begin errors++; $display("FAIL wrap_tmr_clear: got %b want 0", tmr_ip[2]); end
        for (int k = 0; k < 2; k++) begin
            bus(1'b0, rd[k], 32'd0);
            for (int i = 0; i < NI; i++) begin
                e = exp_rdat(i, 1'b0, rd[k], obs_ea);
                checks++; if (obs_rdat[i] !== e) begin errors++; $display("FAIL wrap_read %h inst%0d: got %h want %h", rd[k], i, obs_rdat[i], e); end
            end
        end
    endtask

    task automatic test_backpressure_err();
        int ea;
        logic [31:0] e [NI];
        @(negedge clk);
        req_vld = 1'b1; req_wen = 1'b0; req_addr = 16'hBFF8; req_wdat = 32'd0; rsp_rdy = 1'b0;
        @(posedge clk); #1;
        ea = cyc;
        for (int i = 0; i < NI; i++) e[i] = exp_rdat(i, 1'b0, 16'hBFF8, ea);
        req_wen = 1'b1; req_addr = 16'h0000; req_wdat = 32'h1;
        repeat (3) begin
            @(negedge clk);
            for (int i = 0; i < NI; i++) begin
                checks++; if (rsp_vld[i] !== 1'b1 || rsp_rdat[i] !== e[i] || req_rdy[i] !== 1'b0 || sft_ip[i] !== m_msip) begin
                    errors++; $display("FAIL stall inst%0d: got vld=%b dat=%h rdy=%b sft=%b want 1 %h 0 %b", i, rsp_vld[i], rsp_rdat[i], req_rdy[i], sft_ip[i], e[i], m_msip);
                end
            end
        end
        rsp_rdy = 1'b1;
        @(posedge clk); #1;
        model_write(16'h0000, 32'h1, cyc);
        req_vld = 1'b0;
        @(negedge clk);
        for (int i = 0; i < NI; i++) begin
            checks++; if (rsp_vld[i] !== 1'b1 || rsp_rdat[i] !== 32'd0 || rsp_err[i] !== 1'b0 || sft_ip[i] !== 1'b1) begin
                errors++; $display("FAIL back_to_back inst%0d: got vld=%b dat=%h err=%b sft=%b want 1 0 0 1", i, rsp_vld[i], rsp_rdat[i], rsp_err[i], sft_ip[i]);
            end
        end
        bus(1'b0, 16'h1000, 32'd0);
        checks++; if (obs_err[1] !== 1'b1 || obs_rdat[1] !== 32'd0) begin errors++; $display("FAIL err_read: got err=%b dat=%h want 1 0", obs_err[1], obs_rdat[1]); end
        bus(1'b1, 16'h0004, 32'd0);
        checks++; if (obs_err[1] !== 1'b1) begin errors++; $display("FAIL err_write: got err=%b want 1", obs_err[1]); end
        bus(1'b0, 16'h0000, 32'd0);
        checks++; if (obs_rdat[1] !== 32'h1) begin errors++; $display("FAIL err_no_change: got %h want 00000001", obs_rdat[1]); end
        bus(1'b0, 16'h4003, 32'd0);
        checks++; if (obs_rdat[1] !== 32'd100 || obs_err[1] !== 1'b0) begin errors++; $display("FAIL addr_lsb_ignored: got err=%b dat=%h want 0 00000064", obs_err[1], obs_rdat[1]); end
    endtask

    task automatic test_random();
        logic [15:0] tbl [6] = '{16'h0000, 16'h4000, 16'h4004, 16'hBFF8, 16'hBFFC, 16'h0100};
        logic [15:0] a;
        logic        w;
        logic [31:0] d, e;
        int          k;
        for (int n = 0; n < 40; n++) begin
            k = $urandom_range(0, 5);
            a = (k == 5) ? 16'($urandom) : (tbl[k] | 16'($urandom_range(0, 3)));
            w = 1'($urandom_range(0, 1));
            if (k == 2 || k == 4) d = $urandom_range(0, 1);
            else if (k == 1 || k == 3) d = $urandom_range(0, 300);
            else d = $urandom;
            bus(w, a, d);
            for (int i = 0; i < NI; i++) begin
                e = exp_rdat(i, w, a, obs_ea);
                checks++; if (obs_vld[i] !== 1'b1 || obs_err[i] !== !mapped(a) || obs_rdat[i] !== e) begin
                    errors++; $display("FAIL rand wen=%b addr=%h inst%0d: got vld=%b err=%b dat=%h want 1 %b %h", w, a, i, obs_vld[i], obs_err[i], obs_rdat[i], !mapped(a), e);
                end
            end
            repeat ($urandom_range(0, 3)) begin
                @(posedge clk); #1;
                for (int i = 0; i < NI; i++) begin
                    checks++; if (tmr_ip[i] !== tmr_exp(i, cyc) || sft_ip[i] !== m_msip) begin
                        errors++; $display("FAIL rand_irq inst%0d edge %0d: got tmr=%b sft=%b want %b %b", i, cyc, tmr_ip[i], sft_ip[i], tmr_exp(i, cyc), m_msip);
                    end
                end
            end
        end
    endtask

    task automatic test_reset_midop();
        logic [15:0] rd [3] = '{16'h4000, 16'hBFF8, 16'h0000};
        logic [31:0] e;
        @(negedge clk);
        req_vld = 1'b1; req_wen = 1'b0; req_addr = 16'hBFFC; rsp_rdy = 1'b0;
        @(posedge clk); #1;
        req_vld = 1'b0;
        @(negedge clk);
        checks++; if (rsp_vld[1] !== 1'b1) begin errors++; $display("FAIL midop_pending: got %b want 1", rsp_vld[1]); end
        rst = 1'b1;
        req_vld = 1'b1; req_wen = 1'b1; req_addr = 16'h4000; req_wdat = 32'h1234_5678; rsp_rdy = 1'b1;
        @(posedge clk); #1;
        model_reset(cyc);
        rst = 1'b0; req_vld = 1'b0;
        for (int i = 0; i < NI; i++) begin
            checks++; if (rsp_vld[i] !== 1'b0 || tmr_ip[i] !== 1'b0 || sft_ip[i] !== 1'b0) begin
                errors++; $display("FAIL midop_reset inst%0d: got vld=%b tmr=%b sft=%b want 0 0 0", i, rsp_vld[i], tmr_ip[i], sft_ip[i]);
            end
        end
        for (int k = 0; k < 3; k++) begin
            bus(1'b0, rd[k], 32'd0);
            for (int i = 0; i < NI; i++) begin
                e = exp_rdat(i, 1'b0, rd[k], obs_ea);
                checks++; if (obs_rdat[i] !== e) begin errors++; $display("FAIL midop_read %h inst%0d: got %h want %h", rd[k], i, obs_rdat[i], e); end
            end
            if (k == 0) begin
                checks++; if (obs_rdat[0] !== 32'hFFFF_FFFF) begin errors++; $display("FAIL midop_cmp_discarded: got %h want ffffffff", obs_rdat[0]); end
            end
            if (k == 1) begin
                checks++; if (obs_rdat[0] !== 32'd0) begin errors++; $display("FAIL midop_mtime_zero: got %h want 0", obs_rdat[0]); end
            end
        end
    endtask

    initial begin
        rst = 1'b1; req_vld = 1'b0; req_wen = 1'b0; req_addr = '0; req_wdat = '0; rsp_rdy = 1'b1;
        model_reset(0);
        test_reset();
        test_msip();
        test_timer_cmp();
        test_carry_wrap();
        test_backpressure_err();
        test_random();
        test_reset_midop();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want completion");
        $fatal(1);
    end

endmodule
